// File: rtl/occupancy_pkg.sv
// Shared geometry, types and small helpers for the occupancy grid block.
// The grid matches the 32x24 output of the upstream pixelate stage.
package occupancy_pkg;

    localparam int GRID_W = 32;
    localparam int GRID_H = 24;
    localparam int CW     = 5;
    localparam int NW     = 10;

    localparam int LAST_H = GRID_W - 1;
    localparam int LAST_V = GRID_H - 1;

    typedef logic [GRID_W-1:0] row_t;
    typedef row_t [GRID_H-1:0] grid_t;

    // Increment that sticks at all-ones, so repeated cells cannot wrap the counters.
    function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] a, input logic b);
        if (a == {NW{1'b1}}) begin
            return a;
        end
        return a + NW'(b);
    endfunction

    // True when a coordinate pair addresses a real cell of the grid.
    function automatic logic in_grid(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return ({1'b0, h} < (CW+1)'(GRID_W)) && ({1'b0, v} < (CW+1)'(GRID_H));
    endfunction

endpackage

// File: rtl/grid_frame_ctrl.sv
// Frame bookkeeping for the occupancy grid: filters samples, tracks the
// occupied-cell accumulator and the sample counter, detects frame start
// (restart over a partial frame) and frame end, and produces the registered
// done / dropped / count / valid outputs plus the buffer enables.
module grid_frame_ctrl
    import occupancy_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          data_valid_in,
    input  logic [CW-1:0] hcount_in,
    input  logic [CW-1:0] vcount_in,
    input  logic          pixel_in,
    output logic          accept_o,
    output logic          clear_o,
    output logic          publish_o,
    output logic          frame_done_out,
    output logic          frame_dropped_out,
    output logic          frame_valid_out,
    output logic [NW-1:0] frame_count_out
);

    logic [NW-1:0] acc_q, acc_d;
    logic [NW-1:0] seen_q, seen_d;
    logic [NW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          dropped_q, dropped_d;
    logic          valid_q, valid_d;

    logic          accept;
    logic          at_first;
    logic          at_last;
    logic          publish;
    logic          restart;

    // Classify the incoming sample and compute the next bookkeeping state.
    always_comb begin
        accept    = data_valid_in && in_grid(hcount_in, vcount_in);
        at_first  = (hcount_in == '0) && (vcount_in == '0);
        at_last   = (hcount_in == CW'(LAST_H)) && (vcount_in == CW'(LAST_V));
        publish   = accept && at_last;
        // A (0,0) sample only counts as a restart if a partial frame is pending.
        restart   = accept && at_first && (seen_q != '0);

        acc_d     = acc_q;
        seen_d    = seen_q;
        count_d   = count_q;
        valid_d   = valid_q;
        done_d    = publish;
        dropped_d = restart;

        if (publish) begin
            // Final sample is folded straight into the published count.
            count_d = sat_inc(acc_q, pixel_in);
            valid_d = 1'b1;
            acc_d   = '0;
            seen_d  = '0;
        end else if (restart) begin
            acc_d  = NW'(pixel_in);
            seen_d = NW'(1);
        end else if (accept) begin
            acc_d  = sat_inc(acc_q, pixel_in);
            seen_d = sat_inc(seen_q, 1'b1);
        end
    end

    // Bookkeeping and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q     <= '0;
            seen_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            seen_q    <= seen_d;
            count_q   <= count_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
            valid_q   <= valid_d;
        end
    end

    assign accept_o          = accept;
    assign clear_o           = restart;
    assign publish_o         = publish;
    assign frame_done_out    = done_q;
    assign frame_dropped_out = dropped_q;
    assign frame_valid_out   = valid_q;
    assign frame_count_out   = count_q;

endmodule

// File: rtl/occupancy_grid.sv
// Occupancy grid: assembles a binary bitmap per frame from the pixelate
// sample stream in a write buffer, publishes it to a stable read copy on
// frame end, and serves that copy one registered row per clock.
module occupancy_grid
    import occupancy_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              data_valid_in,
    input  logic [CW-1:0]     hcount_in,
    input  logic [CW-1:0]     vcount_in,
    input  logic              pixel_in,
    input  logic [CW-1:0]     rd_row_in,
    output logic [GRID_W-1:0] rd_data_out,
    output logic              frame_done_out,
    output logic [NW-1:0]     frame_count_out,
    output logic              frame_valid_out,
    output logic              frame_dropped_out
);

    grid_t wbuf_q, wbuf_d;
    grid_t rbuf_q, rbuf_d;
    grid_t merged;
    row_t  rd_data_q, rd_data_d;

    logic  accept;
    logic  clear;
    logic  publish;

    grid_frame_ctrl u_ctrl (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .data_valid_in     (data_valid_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .pixel_in          (pixel_in),
        .accept_o          (accept),
        .clear_o           (clear),
        .publish_o         (publish),
        .frame_done_out    (frame_done_out),
        .frame_dropped_out (frame_dropped_out),
        .frame_valid_out   (frame_valid_out),
        .frame_count_out   (frame_count_out)
    );

    // Next state of both buffers and the read port.
    always_comb begin
        // Write buffer with the current sample already merged in; used as the publish image.
        merged = wbuf_q;
        if (accept) begin
            merged[vcount_in][hcount_in] = pixel_in;
        end

        wbuf_d = wbuf_q;
        rbuf_d = rbuf_q;
        if (publish) begin
            rbuf_d = merged;
            wbuf_d = '0;
        end else if (clear) begin
            // Partial frame is thrown away; only the new (0,0) cell survives.
            wbuf_d       = '0;
            wbuf_d[0][0] = pixel_in;
        end else if (accept) begin
            wbuf_d = merged;
        end

        // Reads always see the pre-edge read copy, so a read on the publish edge returns old data.
        if ({1'b0, rd_row_in} < (CW+1)'(GRID_H)) begin
            rd_data_d = rbuf_q[rd_row_in];
        end else begin
            rd_data_d = '0;
        end
    end

    // Buffer storage and registered read row.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wbuf_q    <= '0;
            rbuf_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wbuf_q    <= wbuf_d;
            rbuf_q    <= rbuf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_out = rd_data_q;

endmodule

// File: tb/tb_occupancy_grid.sv
// Directed testbench for occupancy_grid: full frames of known patterns,
// restart over a partial frame, out-of-range samples, read timing across
// the publish edge, and reset in the middle of a frame.
module tb_occupancy_grid;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [4:0]  hcount;
    logic [4:0]  vcount;
    logic        pixel;
    logic [4:0]  rd_row;
    logic [31:0] rd_data;
    logic        frame_done;
    logic [9:0]  frame_count;
    logic        frame_valid;
    logic        frame_dropped;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int drop_cnt = 0;

    always #5 clk = ~clk;

    occupancy_grid dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .data_valid_in     (data_valid),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .pixel_in          (pixel),
        .rd_row_in         (rd_row),
        .rd_data_out       (rd_data),
        .frame_done_out    (frame_done),
        .frame_count_out   (frame_count),
        .frame_valid_out   (frame_valid),
        .frame_dropped_out (frame_dropped)
    );

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_done)    done_cnt = done_cnt + 1;
        if (frame_dropped) drop_cnt = drop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic p);
        @(negedge clk);
        data_valid = 1'b1;
        hcount     = 5'(h);
        vcount     = 5'(v);
        pixel      = p;
    endtask

    task automatic idle();
        @(negedge clk);
        data_valid = 1'b0;
        pixel      = 1'b0;
    endtask

    task automatic read_row(input int r, output logic [31:0] d);
        @(negedge clk);
        data_valid = 1'b0;
        rd_row     = 5'(r);
        @(negedge clk);
        d = rd_data;
    endtask

    function automatic logic pix(input int kind, input int h, input int v);
        case (kind)
            0: return ((h ^ v) & 1) != 0;
            1: return (h == 5) && (v == 7);
            2: return 1'b1;
            4: return (v == 3) && (h < 4);
            5: return (v == 3) && (h >= 4) && (h < 8);
            6: return (v == 10) && (h < 10);
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_frame(input int kind);
        for (int v = 0; v < 24; v++) begin
            for (int h = 0; h < 32; h++) begin
                drive(h, v, pix(kind, h, v));
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int d_done;
        int d_drop;

        rst        = 1'b1;
        data_valid = 1'b0;
        hcount     = '0;
        vcount     = '0;
        pixel      = 1'b0;
        rd_row     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_done",    32'(frame_done),    32'd0);
        check("rst_count",   32'(frame_count),   32'd0);
        check("rst_valid",   32'(frame_valid),   32'd0);
        check("rst_dropped", 32'(frame_dropped), 32'd0);
        check("rst_rdata",   rd_data,            32'd0);

        // Checkerboard frame
        d_done = done_cnt;
        send_frame(0);
        idle();
        check("chk_done",  32'(frame_done),  32'd1);
        check("chk_count", 32'(frame_count), 32'd384);
        check("chk_valid", 32'(frame_valid), 32'd1);
        idle();
        check("chk_done_1cyc", 32'(frame_done), 32'd0);
        read_row(0, d);
        check("chk_row0", d, 32'hAAAAAAAA);
        read_row(1, d);
        check("chk_row1", d, 32'h55555555);
        check("chk_done_pulses", 32'(done_cnt - d_done), 32'd1);

        // Single occupied cell at (5,7)
        d_done = done_cnt;
        d_drop = drop_cnt;
        send_frame(1);
        idle();
        check("one_done",  32'(frame_done),  32'd1);
        check("one_count", 32'(frame_count), 32'd1);
        check("one_valid", 32'(frame_valid), 32'd1);
        for (int r = 0; r < 24; r++) begin
            read_row(r, d);
            check($sformatf("one_row%0d", r), d, (r == 7) ? 32'h00000020 : 32'h0);
        end
        check("one_done_pulses", 32'(done_cnt - d_done), 32'd1);
        check("one_no_drop",     32'(drop_cnt - d_drop), 32'd0);

        // 100-sample partial frame, then restart with an all-ones frame
        d_done = done_cnt;
        d_drop = drop_cnt;
        for (int i = 0; i < 100; i++) begin
            drive(i % 32, i / 32, 1'b1);
        end
        send_frame(2);
        idle();
        check("ones_done",  32'(frame_done),  32'd1);
        check("ones_count", 32'(frame_count), 32'd768);
        for (int r = 0; r < 24; r++) begin
            read_row(r, d);
            check($sformatf("ones_row%0d", r), d, 32'hFFFFFFFF);
        end
        check("ones_drop_pulses", 32'(drop_cnt - d_drop), 32'd1);
        check("ones_done_pulses", 32'(done_cnt - d_done), 32'd1);

        // All-zero frame with out-of-range samples mixed in
        d_done = done_cnt;
        d_drop = drop_cnt;
        for (int v = 0; v < 24; v++) begin
            for (int h = 0; h < 32; h++) begin
                drive(h, v, 1'b0);
                if (h == 10) drive(0, 24, 1'b1);
                if (h == 20) drive(31, 24, 1'b1);
                if (v == 5 && h == 0) drive(31, 31, 1'b1);
            end
        end
        idle();
        check("oor_done",  32'(frame_done),  32'd1);
        check("oor_count", 32'(frame_count), 32'd0);
        read_row(0, d);
        check("oor_row0", d, 32'h0);
        read_row(23, d);
        check("oor_row23", d, 32'h0);
        check("oor_done_pulses", 32'(done_cnt - d_done), 32'd1);
        check("oor_no_drop",     32'(drop_cnt - d_drop), 32'd0);

        // Read held on row 3 across the publish edge
        send_frame(4);
        idle();
        read_row(3, d);
        check("hold_old_row3", d, 32'h0000000F);
        send_frame(5);
        idle();
        check("hold_done",       32'(frame_done), 32'd1);
        check("hold_edge_row3",  rd_data,         32'h0000000F);
        idle();
        check("hold_after_row3", rd_data,         32'h000000F0);
        read_row(30, d);
        check("rd_row30", d, 32'h0);

        // Reset in the middle of a frame
        d_done = done_cnt;
        d_drop = drop_cnt;
        for (int i = 0; i < 50; i++) begin
            drive(i % 32, i / 32, 1'b1);
        end
        @(negedge clk);
        data_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", 32'(frame_valid), 32'd0);
        check("mrst_count", 32'(frame_count), 32'd0);
        check("mrst_rdata", rd_data,          32'd0);
        send_frame(6);
        idle();
        check("mrst_done",   32'(frame_done),  32'd1);
        check("mrst_count2", 32'(frame_count), 32'd10);
        read_row(10, d);
        check("mrst_row10", d, 32'h000003FF);
        read_row(0, d);
        check("mrst_row0", d, 32'h0);
        read_row(1, d);
        check("mrst_row1", d, 32'h0);
        check("mrst_no_drop",     32'(drop_cnt - d_drop), 32'd0);
        check("mrst_done_pulses", 32'(done_cnt - d_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
